// File: rtl/i2c_slave.sv
// Single-address I2C target: synchronizes SCL/SDA into clk, detects START/STOP,
// ACKs SLAVE_ADDR, delivers written bytes on rx_* and serves read bytes from tx_data.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  logic       r_scl_s1, r_scl_s2, r_scl_prev;
  logic       r_sda_s1, r_sda_s2, r_sda_prev;
  state_t     r_state, w_state_nxt;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_phase, w_phase_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_tx_req;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_shift_in;

  // Idle bus is high, so the synchronizers reset to 1 to avoid a false START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_s1   <= scl;
      r_scl_s2   <= r_scl_s1;
      r_scl_prev <= r_scl_s2;
      r_sda_s1   <= sda;
      r_sda_s2   <= r_sda_s1;
      r_sda_prev <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
  assign w_start    = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;
  assign w_shift_in = {r_shift[6:0], r_sda_s2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_phase    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rw       <= w_rw_nxt;
      r_phase    <= w_phase_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_rw_nxt       = r_rw;
    w_phase_nxt    = r_phase;
    w_sda_oe_nxt   = r_sda_oe;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_tx_req       = 1'b0;
    // Bus conditions override any SCL edge seen in the same cycle.
    if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_bitcnt_nxt = 3'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: if (w_scl_rise) begin
          w_shift_nxt  = w_shift_in;
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            if (w_shift_in[7:1] == SLAVE_ADDR) begin
              w_state_nxt = S_ADDR_ACK;
              w_busy_nxt  = 1'b1;
              w_rw_nxt    = w_shift_in[0];
              w_phase_nxt = 1'b0;
            end else begin
              w_state_nxt = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: if (w_scl_fall) begin
          if (!r_phase) begin
            w_sda_oe_nxt = 1'b1;
            w_phase_nxt  = 1'b1;
          end else begin
            w_phase_nxt  = 1'b0;
            w_bitcnt_nxt = 3'd0;
            if (r_rw) begin
              w_tx_req     = 1'b1;
              w_shift_nxt  = tx_data;
              w_sda_oe_nxt = ~tx_data[7];
              w_state_nxt  = S_READ;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_WRITE;
            end
          end
        end
        S_WRITE: if (w_scl_rise) begin
          w_shift_nxt  = w_shift_in;
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_rx_data_nxt  = w_shift_in;
            w_rx_valid_nxt = 1'b1;
            w_phase_nxt    = 1'b0;
            w_state_nxt    = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: if (w_scl_fall) begin
          if (!r_phase) begin
            w_sda_oe_nxt = 1'b1;
            w_phase_nxt  = 1'b1;
          end else begin
            w_sda_oe_nxt = 1'b0;
            w_phase_nxt  = 1'b0;
            w_state_nxt  = S_WRITE;
          end
        end
        S_READ: if (w_scl_fall) begin
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_sda_oe_nxt = 1'b0;
            w_phase_nxt  = 1'b0;
            w_state_nxt  = S_READ_ACK;
          end else begin
            // Rotate rather than shift so every register bit stays live.
            w_shift_nxt  = {r_shift[6:0], r_shift[7]};
            w_sda_oe_nxt = ~r_shift[6];
          end
        end
        S_READ_ACK: begin
          if (w_scl_rise && !r_phase) begin
            if (!r_sda_s2) begin
              w_phase_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IGNORE;
              w_busy_nxt  = 1'b0;
            end
          end else if (w_scl_fall && r_phase) begin
            w_tx_req     = 1'b1;
            w_shift_nxt  = tx_data;
            w_sda_oe_nxt = ~tx_data[7];
            w_bitcnt_nxt = 3'd0;
            w_phase_nxt  = 1'b0;
            w_state_nxt  = S_READ;
          end
        end
        S_IDLE, S_IGNORE: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign tx_req   = w_tx_req;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Single-address I2C target that sits on the SDA/SCL bus driven by `i2c_master` and consumes its transactions. Samples the bus in the shared system clock domain and detects START/STOP. Matches a 7-bit address, ACKs it, and hands written bytes to the user side. Serves read bytes from the user side. Replaces the missing slave model in the master bench and serves as the on-chip target for loopback.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target responds to.
- `clk`  in  1: system clock, same clock as `i2c_master`.
- `rst_n`  in  1: asynchronous, active-low reset.
- `scl`  in  1: bus clock; this block never stretches it.
- `sda`  inout  1: open-drain data line. Driven `1'b0` when the internal `sda_oe` is set, `1'bz` otherwise. External pull-up.
- `tx_data`  in  8: byte returned on a read; sampled in the cycle `tx_req` is high.
- `tx_req`  out  1: one-cycle pulse; `tx_data` is captured in this cycle.
- `rx_data`  out  8: last byte written by the master; holds until the next write byte.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` updates.
- `busy`  out  1: high from address match until STOP, repeated START or NACK-end of a read.

## Operation
- **Input conditioning**
  - `scl` and `sda` pass through 2-flop synchronizers, then a third "previous" register.
  - Edges are computed from the synchronized and previous values.
- **Bus conditions**
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are checked every cycle, in every state, and have priority over bit processing.
- **States:** IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- **IDLE / START**
  - START from any state → ADDR, bit counter 0, `sda` released. This covers repeated START.
  - STOP from any state → IDLE, `sda` released, `busy`=0.
- **ADDR**
  - Shift SDA MSB-first on each SCL rising edge; 8 bits form {addr[6:0], rw}.
  - On the 8th bit: addr == `SLAVE_ADDR` → ADDR_ACK and `busy`=1; mismatch → IGNORE.
- **ADDR_ACK**
  - On the next SCL falling edge, pull SDA low.
  - On the following falling edge, release SDA.
  - rw=0 → WRITE.
  - rw=1 → READ: pulse `tx_req`, latch `tx_data` into the shift register, drive the MSB in the same cycle.
- **WRITE**
  - Sample 8 bits on rising edges.
  - On the 8th: `rx_data` ← shifted byte, `rx_valid` pulses, → WRITE_ACK.
- **WRITE_ACK**
  - Pull SDA low from the next falling edge to the one after, then → WRITE.
  - Unlimited bytes per transaction.
- **READ**
  - On each SCL falling edge, drive the next bit (bit=0 → pull low, bit=1 → release).
  - After the 8th bit's falling edge, release SDA → READ_ACK.
- **READ_ACK**
  - Sample SDA on the rising edge.
  - 0 (ACK) → on the next falling edge pulse `tx_req`, load `tx_data`, drive MSB, → READ.
  - 1 (NACK) → IGNORE, `busy`=0.
- **IGNORE**
  - SDA released; waits for START or STOP.
- **Bit counter:** 3-bit, wraps 7→0 at each byte boundary.

## Timing
- **Reset values:** `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, SDA released, state IDLE.
- **Reset mid-transaction:** SDA released asynchronously. The bus is ignored until the next START.
- **Edge detection latency:** 3 clk after a bus edge (2 sync + 1 compare).
- **SDA drive:** all changes occur 3 clk after the SCL falling edge, which gives SDA hold time after SCL low.
- **`rx_valid`:** asserts 3 clk after the 8th data-bit SCL rising edge.
- **Bus timing requirements:**
  - SCL high and low phases ≥ 4 clk each.
  - SDA set-up to SCL rising ≥ 3 clk.
- **Simultaneous events:** START/STOP in the same cycle as an SCL edge — START/STOP wins and the bit is discarded.
- **STOP mid-byte:** partial byte dropped, no `rx_valid`.
- **Outputs:** `rx_valid` and `tx_req` are never high in the same cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ACK with SDA pulled low → SDA released immediately. After release, all outputs at reset values and no ACK until a new START.
- **Write:** master writes addr 7'h50 W, data 8'hA5 → SDA low on both 9th clocks. `rx_data`=8'hA5, `rx_valid` exactly one 1-clk pulse, `busy` 1→0 at STOP.
- **Address mismatch:** master addresses 7'h51 W, data 8'h11 → SDA never pulled low, no `rx_valid`, `busy`=0 throughout, `rx_data` unchanged.
- **Read:** addr 7'h50 R with `tx_data`=8'h3C, master ACKs, `tx_data` changed to 8'hC3 after the first `tx_req`, master NACKs → master receives 8'h3C then 8'hC3. Two `tx_req` pulses, SDA released after the 2nd byte, `busy`=0.
- **Repeated START:** write 8'h5A, then repeated START with addr 7'h50 R → state returns to ADDR without STOP, address ACKed, `rx_valid` pulsed once for 8'h5A.
- **STOP mid-byte:** STOP after 4 data bits of a write → IDLE, no `rx_valid`. The next full write of 8'h0F is received correctly.
